// File: rtl/ddr4_seq_pkg.sv
// Shared types and defaults for the DDR4 reset sequencer.
// Holds the FSM state encoding, LED bit positions and default timing.
package ddr4_seq_pkg;

  typedef enum logic [2:0] {
    StInit,
    StReq,
    StWaitCal,
    StHold,
    StRun,
    StFail
  } state_e;

  localparam int unsigned LedRun  = 0;
  localparam int unsigned LedCal  = 1;
  localparam int unsigned LedFail = 2;
  localparam int unsigned LedBeat = 3;

  localparam int unsigned DefSyncStages      = 2;
  localparam int unsigned DefDebounceCycles  = 500000;
  localparam int unsigned DefReqPulseCycles  = 16;
  localparam int unsigned DefCalTimeoutCycles = 50000000;
  localparam int unsigned DefHoldCycles      = 1024;
  localparam int unsigned DefMaxRetries      = 3;
  localparam int unsigned HeartbeatBits      = 24;

  // Counter width for a terminal count of n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr4_reset_sequencer_sync_debounce.sv
// Multi-stage synchroniser with an optional debounce filter on the synced value.
// DEBOUNCE_CYCLES = 0 gives a plain synchroniser.
module sync_debounce
  import ddr4_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DefSyncStages,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter bit          RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(din);
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_sync_only
    assign dout = synced;
  end else begin : g_debounce
    localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] cnt_q;
    logic            db_q;

    // A new level is accepted only after it has differed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
        db_q  <= RESET_VAL;
      end else if (synced == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        cnt_q <= '0;
        db_q  <= synced;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end

    assign dout = db_q;
  end

endmodule

// File: rtl/ddr4_reset_sequencer.sv
// Holds the Qsys system in reset until DDR4 calibration succeeds and stays stable,
// retrying calibration on failure or timeout and reporting status on the LEDs.
module ddr4_reset_sequencer
  import ddr4_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = DefSyncStages,
  parameter int unsigned DEBOUNCE_CYCLES    = DefDebounceCycles,
  parameter int unsigned REQ_PULSE_CYCLES   = DefReqPulseCycles,
  parameter int unsigned CAL_TIMEOUT_CYCLES = DefCalTimeoutCycles,
  parameter int unsigned HOLD_CYCLES        = DefHoldCycles,
  parameter int unsigned MAX_RETRIES        = DefMaxRetries
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       ninit_done,
  input  logic       cpu_reset_n,
  input  logic       cal_success,
  input  logic       cal_fail,
  output logic       ddr4_local_reset_req,
  output logic       sys_reset,
  output logic [1:0] retry_count,
  output logic [3:0] led
);

  localparam int unsigned ReqW  = cnt_width(REQ_PULSE_CYCLES);
  localparam int unsigned ToW   = cnt_width(CAL_TIMEOUT_CYCLES);
  localparam int unsigned HoldW = cnt_width(HOLD_CYCLES);
  localparam logic [ReqW-1:0]  ReqLast  = ReqW'(REQ_PULSE_CYCLES - 1);
  localparam logic [ToW-1:0]   ToLast   = ToW'(CAL_TIMEOUT_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  logic ninit_s, btn_db, cal_ok_s, cal_fail_s, btn_press;

  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(0), .RESET_VAL(1'b1)) u_sync_ninit (
    .clk(clk_clk), .rst(reset_reset), .din(ninit_done), .dout(ninit_s)
  );
  sync_debounce #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)
  ) u_sync_btn (
    .clk(clk_clk), .rst(reset_reset), .din(cpu_reset_n), .dout(btn_db)
  );
  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(0), .RESET_VAL(1'b0)) u_sync_cal_ok (
    .clk(clk_clk), .rst(reset_reset), .din(cal_success), .dout(cal_ok_s)
  );
  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(0), .RESET_VAL(1'b0)) u_sync_cal_fail (
    .clk(clk_clk), .rst(reset_reset), .din(cal_fail), .dout(cal_fail_s)
  );

  state_e                   state_q, state_d;
  logic [ReqW-1:0]          req_cnt_q, req_cnt_d;
  logic [ToW-1:0]           to_cnt_q, to_cnt_d;
  logic [HoldW-1:0]         hold_cnt_q, hold_cnt_d;
  logic [1:0]               retry_q, retry_d;
  logic                     btn_prev_q;
  logic [HeartbeatBits-1:0] hb_cnt_q;
  logic                     hb_q;
  logic [2:0]               led_q;

  assign btn_press = btn_prev_q & ~btn_db;

  always_comb begin
    state_d    = state_q;
    req_cnt_d  = req_cnt_q;
    to_cnt_d   = to_cnt_q;
    hold_cnt_d = hold_cnt_q;
    retry_d    = retry_q;
    if (btn_press) begin
      state_d    = StInit;
      req_cnt_d  = '0;
      to_cnt_d   = '0;
      hold_cnt_d = '0;
      retry_d    = '0;
    end else begin
      unique case (state_q)
        StInit: begin
          if (!ninit_s && btn_db) begin
            state_d   = StReq;
            req_cnt_d = '0;
          end
        end
        StReq: begin
          if (req_cnt_q == ReqLast) begin
            state_d  = StWaitCal;
            to_cnt_d = '0;
          end else begin
            req_cnt_d = req_cnt_q + ReqW'(1);
          end
        end
        StWaitCal: begin
          // Fail wins over a simultaneous success report.
          if (cal_fail_s || (to_cnt_q == ToLast)) begin
            if ((32'(retry_q) < MAX_RETRIES) && (retry_q != 2'd3)) begin
              retry_d   = retry_q + 2'd1;
              state_d   = StReq;
              req_cnt_d = '0;
            end else begin
              state_d = StFail;
            end
          end else if (cal_ok_s) begin
            state_d    = StHold;
            hold_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + ToW'(1);
          end
        end
        StHold: begin
          if (!cal_ok_s || cal_fail_s) begin
            state_d  = StWaitCal;
            to_cnt_d = '0;
          end else if (hold_cnt_q == HoldLast) begin
            state_d = StRun;
          end else begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end
        end
        StRun: begin
          if (!cal_ok_s || cal_fail_s) state_d = StInit;
        end
        StFail: state_d = StFail;
        default: state_d = StInit;
      endcase
    end
  end

  // Outputs are registered from the next state so they change in the same cycle as the state.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q              <= StInit;
      req_cnt_q            <= '0;
      to_cnt_q             <= '0;
      hold_cnt_q           <= '0;
      retry_q              <= '0;
      btn_prev_q           <= 1'b1;
      sys_reset            <= 1'b1;
      ddr4_local_reset_req <= 1'b0;
      led_q                <= '0;
      hb_cnt_q             <= '0;
      hb_q                 <= 1'b0;
    end else begin
      state_q              <= state_d;
      req_cnt_q            <= req_cnt_d;
      to_cnt_q             <= to_cnt_d;
      hold_cnt_q           <= hold_cnt_d;
      retry_q              <= retry_d;
      btn_prev_q           <= btn_db;
      sys_reset            <= (state_d != StRun);
      ddr4_local_reset_req <= (state_d == StReq);
      led_q[LedRun]        <= (state_d == StRun);
      led_q[LedCal]        <= (state_d == StWaitCal) || (state_d == StHold);
      led_q[LedFail]       <= (state_d == StFail);
      hb_cnt_q             <= hb_cnt_q + HeartbeatBits'(1);
      if (&hb_cnt_q) hb_q <= ~hb_q;
    end
  end

  assign retry_count          = retry_q;
  assign led[LedFail:LedRun]  = led_q;
  assign led[LedBeat]         = hb_q;

endmodule

// File: tb/tb_ddr4_reset_sequencer.sv
// Directed bench for ddr4_reset_sequencer with shortened timing parameters.
module tb_ddr4_reset_sequencer;

  localparam int unsigned DbCyc   = 4;
  localparam int unsigned ToCyc   = 100;
  localparam int unsigned HoldCyc = 8;
  localparam int unsigned ReqCyc  = 16;

  logic       clk_clk = 1'b0;
  logic       reset_reset = 1'b1;
  logic       ninit_done = 1'b1;
  logic       cpu_reset_n = 1'b1;
  logic       cal_success = 1'b0;
  logic       cal_fail = 1'b0;
  logic       ddr4_local_reset_req;
  logic       sys_reset;
  logic [1:0] retry_count;
  logic [3:0] led;

  int tests = 0;
  int fails = 0;

  always #10 clk_clk = ~clk_clk;

  ddr4_reset_sequencer #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(DbCyc),
    .REQ_PULSE_CYCLES(ReqCyc),
    .CAL_TIMEOUT_CYCLES(ToCyc),
    .HOLD_CYCLES(HoldCyc),
    .MAX_RETRIES(3)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .ninit_done(ninit_done),
    .cpu_reset_n(cpu_reset_n),
    .cal_success(cal_success),
    .cal_fail(cal_fail),
    .ddr4_local_reset_req(ddr4_local_reset_req),
    .sys_reset(sys_reset),
    .retry_count(retry_count),
    .led(led)
  );

  typedef struct {
    logic       rst;
    logic       ninit;
    logic       btn;
    logic       ok;
    logic       fail;
    int         cycles;
    logic       exp_sr;
    logic       exp_req;
    logic [1:0] exp_retry;
    logic [3:0] exp_led;
  } vec_t;

  vec_t vecs[7];

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return ddr4_local_reset_req;
      1:       return sys_reset;
      default: return led[2];
    endcase
  endfunction

  // Counts cycles until the selected output reaches lvl; an expired bound is a failure.
  task automatic wait_sig(input string name, input int sel, input logic lvl, input int bound,
                          output int n);
    n = 0;
    while (sig(sel) !== lvl && n < bound) begin
      tick();
      n++;
    end
    if (sig(sel) !== lvl) begin
      tests++;
      fails++;
      $display("FAIL %s: level %0b not reached within %0d cycles", name, lvl, bound);
    end
  endtask

  task automatic press_button(input int low_cycles);
    cpu_reset_n = 1'b0;
    tick(low_cycles);
    cpu_reset_n = 1'b1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    logic req_seen;
    int bad;

    //           rst   ninit btn   ok    fail  cyc sr    req   retry  led
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 2'd0, 4'b0000};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10, 1'b1, 1'b0, 2'd0, 4'b0000};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b0, 2'd0, 4'b0000};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6, 1'b1, 1'b0, 2'd0, 4'b0000};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 2'd0, 4'b0000};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5, 1'b1, 1'b1, 2'd0, 4'b0000};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 2'd0, 4'b0000};

    for (int i = 0; i < 7; i++) begin
      reset_reset = vecs[i].rst;
      ninit_done  = vecs[i].ninit;
      cpu_reset_n = vecs[i].btn;
      cal_success = vecs[i].ok;
      cal_fail    = vecs[i].fail;
      tick(vecs[i].cycles);
      check($sformatf("vec%0d_sys_reset", i), 32'(sys_reset), 32'(vecs[i].exp_sr));
      check($sformatf("vec%0d_req", i), 32'(ddr4_local_reset_req), 32'(vecs[i].exp_req));
      check($sformatf("vec%0d_retry", i), 32'(retry_count), 32'(vecs[i].exp_retry));
      check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
    end

    // Nominal bring-up.
    reset_reset = 1'b0;
    wait_sig("nom_req_rise", 0, 1'b1, 10, n);
    check("nom_req_latency", n, 3);
    wait_sig("nom_req_fall", 0, 1'b0, 40, n);
    check("nom_req_width", n, ReqCyc);
    tick(20);
    check("nom_led_waitcal", 32'(led), 32'b0010);
    cal_success = 1'b1;
    tick(10);
    check("nom_sysrst_held", 32'(sys_reset), 1);
    tick(1);
    check("nom_sysrst_released", 32'(sys_reset), 0);
    check("nom_led_run", 32'(led), 32'b0001);
    check("nom_retry", 32'(retry_count), 0);

    // Loss of calibration in RUN, then a failed attempt followed by success.
    cal_success = 1'b0;
    tick(2);
    check("run_still_released", 32'(sys_reset), 0);
    tick(1);
    check("run_loss_sysrst", 32'(sys_reset), 1);
    wait_sig("c_req_rise", 0, 1'b1, 10, n);
    wait_sig("c_req_fall", 0, 1'b0, 40, n);
    check("c_req_width", n, ReqCyc);
    cal_fail = 1'b1;
    tick();
    cal_fail = 1'b0;
    wait_sig("c_retry_rise", 0, 1'b1, 10, n);
    check("c_retry_gap", n + 1, 3);
    check("c_retry_count", 32'(retry_count), 1);
    wait_sig("c_retry_fall", 0, 1'b0, 40, n);
    check("c_retry_width", n, ReqCyc);
    cal_success = 1'b1;
    wait_sig("c_run", 1, 1'b0, 20, n);
    check("c_run_latency", n, 11);
    check("c_led_run", 32'(led), 32'b0001);

    // One-cycle drop of cal_success at hold count 5 restarts the hold without a retry.
    cal_success = 1'b0;
    wait_sig("d_req_rise", 0, 1'b1, 10, n);
    wait_sig("d_req_fall", 0, 1'b0, 40, n);
    cal_success = 1'b1;
    req_seen = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      tick();
      req_seen |= ddr4_local_reset_req;
      if (i == 6) cal_success = 1'b0;
      if (i == 7) cal_success = 1'b1;
      if (i == 17) check("d_sysrst_held", 32'(sys_reset), 1);
    end
    check("d_sysrst_released", 32'(sys_reset), 0);
    check("d_no_req", 32'(req_seen), 0);
    check("d_retry_kept", 32'(retry_count), 1);

    // Button press in the middle of a request pulse.
    cal_success = 1'b0;
    wait_sig("e_req_rise", 0, 1'b1, 10, n);
    cpu_reset_n = 1'b0;
    tick(6);
    check("e_req_before_press", 32'(ddr4_local_reset_req), 1);
    cpu_reset_n = 1'b1;
    tick(1);
    check("e_req_dropped", 32'(ddr4_local_reset_req), 0);
    check("e_retry_cleared", 32'(retry_count), 0);
    check("e_sysrst", 32'(sys_reset), 1);
    check("e_led_init", 32'(led), 32'b0000);

    // Calibration never reports: four attempts, then FAIL.
    for (int a = 0; a < 4; a++) begin
      wait_sig($sformatf("t%0d_req_rise", a), 0, 1'b1, (a == 0) ? 20 : 110, n);
      if (a > 0) check($sformatf("t%0d_timeout_gap", a), n, ToCyc);
      check($sformatf("t%0d_retry", a), 32'(retry_count), a);
      wait_sig($sformatf("t%0d_req_fall", a), 0, 1'b0, 40, n);
      check($sformatf("t%0d_req_width", a), n, ReqCyc);
    end
    wait_sig("t_fail_entry", 2, 1'b1, 110, n);
    check("t_fail_latency", n, ToCyc);
    check("t_fail_led", 32'(led), 32'b0100);
    check("t_fail_retry", 32'(retry_count), 3);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ddr4_local_reset_req !== 1'b0 || sys_reset !== 1'b1 || led !== 4'b0100) bad++;
    end
    check("t_fail_terminal", bad, 0);

    // Short glitch is filtered; a real press leaves FAIL.
    press_button(2);
    tick(10);
    check("f_glitch_led", 32'(led), 32'b0100);
    check("f_glitch_retry", 32'(retry_count), 3);
    cpu_reset_n = 1'b0;
    tick(6);
    check("f_still_fail", 32'(led), 32'b0100);
    cpu_reset_n = 1'b1;
    tick(1);
    check("f_press_led", 32'(led), 32'b0000);
    check("f_press_retry", 32'(retry_count), 0);
    check("f_press_sysrst", 32'(sys_reset), 1);

    // Success and fail together are a failure.
    wait_sig("g_req_rise", 0, 1'b1, 20, n);
    wait_sig("g_req_fall", 0, 1'b0, 40, n);
    cal_success = 1'b1;
    cal_fail    = 1'b1;
    wait_sig("g_retry_rise", 0, 1'b1, 10, n);
    check("g_retry_gap", n, 3);
    check("g_retry_count", 32'(retry_count), 1);
    check("g_sysrst", 32'(sys_reset), 1);
    cal_success = 1'b0;
    cal_fail    = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
